// File: rtl/mem_access_stage.sv
// Memory-access stage behind the execute ALU: runs loads/stores over a req/gnt/rvalid port, passes other results through.
// Emits a one-cycle writeback pulse; accepts a new op only when idle.
module mem_access_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       in_op,
  input  logic [WIDTH-1:0] in_result,
  input  logic [WIDTH-1:0] in_store_data,
  input  logic [4:0]       in_rd,
  output logic             mem_req,
  input  logic             mem_gnt,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [3:0]       mem_be,
  output logic [31:0]      mem_wdata,
  input  logic             mem_rvalid,
  input  logic [31:0]      mem_rdata,
  output logic             wb_valid,
  output logic [4:0]       wb_rd,
  output logic [WIDTH-1:0] wb_data,
  output logic             misalign_err
);

  localparam logic [5:0] I_LB  = 6'h01;
  localparam logic [5:0] I_LH  = 6'h02;
  localparam logic [5:0] I_LW  = 6'h03;
  localparam logic [5:0] I_LBU = 6'h04;
  localparam logic [5:0] I_LHU = 6'h05;
  localparam logic [5:0] I_SB  = 6'h06;
  localparam logic [5:0] I_SH  = 6'h07;
  localparam logic [5:0] I_SW  = 6'h08;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, WB} state_t;

  state_t      state, state_nxt;
  logic [5:0]  op_q;
  logic [1:0]  off_q;
  logic        accept;
  logic        in_mem, in_store, in_misaligned;
  logic [3:0]  in_be;
  logic [31:0] in_wdata;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_val;

  assign accept   = in_valid && in_ready;
  assign in_ready = (state == IDLE);
  assign mem_req  = (state == REQ);
  assign wb_valid = (state == WB);

  // Decode of the incoming op: lane mask, replicated store data, alignment.
  always_comb begin
    in_mem        = 1'b0;
    in_store      = 1'b0;
    in_misaligned = 1'b0;
    in_be         = 4'b0000;
    in_wdata      = 32'h0;
    case (in_op)
      I_LB, I_LBU, I_SB: begin
        in_mem   = 1'b1;
        in_store = (in_op == I_SB);
        in_be    = 4'b0001 << in_result[1:0];
        if (in_store) in_wdata = {4{in_store_data[7:0]}};
      end
      I_LH, I_LHU, I_SH: begin
        in_mem        = 1'b1;
        in_store      = (in_op == I_SH);
        in_misaligned = in_result[0];
        in_be         = in_result[1] ? 4'b1100 : 4'b0011;
        if (in_store) in_wdata = {2{in_store_data[15:0]}};
      end
      I_LW, I_SW: begin
        in_mem        = 1'b1;
        in_store      = (in_op == I_SW);
        in_misaligned = (in_result[1:0] != 2'b00);
        in_be         = 4'b1111;
        if (in_store) in_wdata = in_store_data[31:0];
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_byte  = mem_rdata[{off_q, 3'b000} +: 8];
    rd_half  = mem_rdata[{off_q[1], 4'b0000} +: 16];
    load_val = mem_rdata;
    case (op_q)
      I_LB:    load_val = {{24{rd_byte[7]}}, rd_byte};
      I_LBU:   load_val = {24'h0, rd_byte};
      I_LH:    load_val = {{16{rd_half[15]}}, rd_half};
      I_LHU:   load_val = {16'h0, rd_half};
      default: load_val = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!in_mem)            state_nxt = WB;
          else if (!in_misaligned) state_nxt = REQ;
        end
      end
      // rvalid is deliberately not looked at here; the bus returns data after gnt.
      REQ:     if (mem_gnt) state_nxt = mem_we ? IDLE : WAIT_R;
      WAIT_R:  if (mem_rvalid) state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q         <= 6'h0;
      off_q        <= 2'b00;
      mem_we       <= 1'b0;
      mem_addr     <= 32'h0;
      mem_be       <= 4'b0000;
      mem_wdata    <= 32'h0;
      wb_rd        <= 5'h0;
      wb_data      <= '0;
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= 1'b0;
      if (accept) begin
        op_q  <= in_op;
        off_q <= in_result[1:0];
        wb_rd <= in_rd;
        if (!in_mem) begin
          wb_data <= in_result;
        end else if (in_misaligned) begin
          misalign_err <= 1'b1;
        end else begin
          mem_addr  <= {in_result[31:2], 2'b00};
          mem_we    <= in_store;
          mem_be    <= in_be;
          mem_wdata <= in_wdata;
        end
      end
      if (state == WAIT_R && mem_rvalid) wb_data <= load_val;
    end
  end

endmodule
